// File: rtl/ma_decim_fifo.sv
// Decimator plus show-ahead FIFO behind the moving-average filter.
// Optional drop counter enabled by `MA_DECIM_DROP_CNT_EN`.
module ma_decim_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_sample,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sample,
    output logic [AW:0]             fifo_level,
    output logic                    overflow,
    output logic [15:0]             drop_cnt
);

    localparam logic [7:0]  PhLast   = 8'(DECIM - 1);
    localparam logic [AW:0] LvlFull  = (AW + 1)'(DEPTH);

    logic [7:0]       ph_q, ph_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             keep, pop, full, push, drop, wr_en;

    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    // Empty FIFO reads as zero so the head is never X after reset.
    assign out_sample = out_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        keep     = in_valid && (ph_q == 8'd0);
        pop      = out_valid && out_ready;
        full     = (level_q == LvlFull);
        push     = keep && (!full || pop);
        drop     = keep && full && !pop;
        wr_en    = push && !clear;
        ph_d     = ph_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clear) begin
            ph_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (in_valid) begin
                ph_d = (ph_q == PhLast) ? 8'd0 : ph_q + 8'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_sample;
        end
    end

`ifdef MA_DECIM_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ma_decim_fifo.sv
// Directed bench for ma_decim_fifo: three instances (DECIM 4, 1, 2) share one stimulus stream.
module tb_ma_decim_fifo;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, clear, out_ready;
    logic [15:0] in_sample;

    logic        v4, v1, v2, o4, o1, o2;
    logic [15:0] s4, s1, s2, d4, d1, d2;
    logic [3:0]  l4, l1, l2;

    int total = 0;
    int bad   = 0;

`ifdef MA_DECIM_DROP_CNT_EN
    localparam int DcEn = 1;
`else
    localparam int DcEn = 0;
`endif

    always #5 clk = ~clk;

    ma_decim_fifo #(.WIDTH(16), .DECIM(4), .DEPTH(8), .AW(3)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample), .clear(clear),
        .out_valid(v4), .out_ready(out_ready), .out_sample(s4), .fifo_level(l4),
        .overflow(o4), .drop_cnt(d4)
    );
    ma_decim_fifo #(.WIDTH(16), .DECIM(1), .DEPTH(8), .AW(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample), .clear(clear),
        .out_valid(v1), .out_ready(out_ready), .out_sample(s1), .fifo_level(l1),
        .overflow(o1), .drop_cnt(d1)
    );
    ma_decim_fifo #(.WIDTH(16), .DECIM(2), .DEPTH(8), .AW(3)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample), .clear(clear),
        .out_valid(v2), .out_ready(out_ready), .out_sample(s2), .fifo_level(l2),
        .overflow(o2), .drop_cnt(d2)
    );

    typedef struct {
        logic        vld;
        logic [15:0] smp;
        logic        exp_vld;
        logic [15:0] exp_smp;
        logic [3:0]  exp_lvl;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sample = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [15:0] heads[8];

    initial begin
        // DECIM=4 stream 0..11 with out_ready=1: kept 0, 4, 8 each visible for one cycle.
        tbl[0]  = '{1'b1, 16'd0,  1'b1, 16'd0, 4'd1};
        tbl[1]  = '{1'b1, 16'd1,  1'b0, 16'd0, 4'd0};
        tbl[2]  = '{1'b1, 16'd2,  1'b0, 16'd0, 4'd0};
        tbl[3]  = '{1'b1, 16'd3,  1'b0, 16'd0, 4'd0};
        tbl[4]  = '{1'b1, 16'd4,  1'b1, 16'd4, 4'd1};
        tbl[5]  = '{1'b1, 16'd5,  1'b0, 16'd0, 4'd0};
        tbl[6]  = '{1'b1, 16'd6,  1'b0, 16'd0, 4'd0};
        tbl[7]  = '{1'b1, 16'd7,  1'b0, 16'd0, 4'd0};
        tbl[8]  = '{1'b1, 16'd8,  1'b1, 16'd8, 4'd1};
        tbl[9]  = '{1'b1, 16'd9,  1'b0, 16'd0, 4'd0};
        tbl[10] = '{1'b1, 16'd10, 1'b0, 16'd0, 4'd0};
        tbl[11] = '{1'b1, 16'd11, 1'b0, 16'd0, 4'd0};
        heads = '{16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107, 16'd500};

        do_reset();
        chk("rst_valid", 32'(v4), 32'd0);
        chk("rst_sample", 32'(s4), 32'd0);
        chk("rst_level", 32'(l4), 32'd0);
        chk("rst_ovf", 32'(o4), 32'd0);
        chk("rst_drop", 32'(d4), 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].vld;
            in_sample = tbl[i].smp;
            step();
            chk($sformatf("d4_valid[%0d]", i), 32'(v4), 32'(tbl[i].exp_vld));
            chk($sformatf("d4_level[%0d]", i), 32'(l4), 32'(tbl[i].exp_lvl));
            if (tbl[i].exp_vld) chk($sformatf("d4_sample[%0d]", i), 32'(s4), 32'(tbl[i].exp_smp));
            chk($sformatf("d4_ovf[%0d]", i), 32'(o4), 32'd0);
        end

        // DECIM=1 overflow: 100..109 with out_ready=0, last two dropped.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_sample = 16'(100 + k);
            step();
            chk($sformatf("fill_level[%0d]", k), 32'(l1), (k < 8) ? 32'(k + 1) : 32'd8);
            chk($sformatf("fill_head[%0d]", k), 32'(s1), 32'd100);
            chk($sformatf("fill_ovf[%0d]", k), 32'(o1), (k >= 8) ? 32'd1 : 32'd0);
        end
        chk("fill_drop", 32'(d1), 32'(2 * DcEn));

        // Full FIFO, simultaneous pop and kept sample 500: accepted, no drop.
        in_sample = 16'd500;
        out_ready = 1'b1;
        step();
        chk("fullpp_level", 32'(l1), 32'd8);
        chk("fullpp_drop", 32'(d1), 32'(2 * DcEn));
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_head[%0d]", i), 32'(s1), 32'(heads[i]));
            step();
        end
        chk("drain_valid", 32'(v1), 32'd0);
        chk("drain_level", 32'(l1), 32'd0);
        chk("drain_ovf_sticky", 32'(o1), 32'd1);

        // DECIM=2 gapped input: valid samples 10,20,30,40 -> kept 10 and 30.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid  = (i % 3 == 0);
            in_sample = 16'(10 * (i / 3 + 1));
            step();
        end
        in_valid = 1'b0;
        chk("gap_level", 32'(l2), 32'd2);
        chk("gap_head0", 32'(s2), 32'd10);
        out_ready = 1'b1;
        step();
        chk("gap_head1", 32'(s2), 32'd30);
        chk("gap_level1", 32'(l2), 32'd1);
        step();
        chk("gap_empty", 32'(v2), 32'd0);

        // clear with level 5, overflow set, and a concurrent sample 77 plus pop request.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            in_valid  = 1'b1;
            in_sample = 16'(200 + k);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("pre_clr_level", 32'(l1), 32'd5);
        chk("pre_clr_ovf", 32'(o1), 32'd1);
        chk("pre_clr_drop", 32'(d1), 32'(DcEn));
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'd77;
        step();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("clr_level", 32'(l1), 32'd0);
        chk("clr_valid", 32'(v1), 32'd0);
        chk("clr_ovf", 32'(o1), 32'd0);
        chk("clr_drop", 32'(d1), 32'd0);
        chk("clr_level_d4", 32'(l4), 32'd0);
        in_valid  = 1'b1;
        in_sample = 16'd88;
        step();
        in_valid = 1'b0;
        chk("post_clr_head", 32'(s1), 32'd88);
        chk("post_clr_level", 32'(l1), 32'd1);
        chk("post_clr_d4_kept", 32'(l4), 32'd1);
        chk("post_clr_d4_head", 32'(s4), 32'd88);

        // Asynchronous reset mid-burst.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_sample = 16'(300 + k);
            step();
        end
        chk("pre_arst_level", 32'(l1), 32'd3);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_valid", 32'(v1), 32'd0);
        chk("arst_level", 32'(l1), 32'd0);
        chk("arst_sample", 32'(s1), 32'd0);
        chk("arst_level_d4", 32'(l4), 32'd0);
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'd55;
        step();
        in_valid = 1'b0;
        chk("post_arst_d4_level", 32'(l4), 32'd1);
        chk("post_arst_d4_head", 32'(s4), 32'd55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ma_decim_fifo.md
# ma_decim_fifo

Downstream stage of the moving-average filter: takes its `out_valid`/`out_sample` stream, keeps one sample in every DECIM, and buffers the kept samples in a small show-ahead FIFO. The FIFO drains to a consumer over a valid/ready handshake. The filter cannot be back-pressured, so this block absorbs consumer stalls, drops samples on overflow and reports the drops.

## Interface
- WIDTH, 16, sample width (matches filter WIDTH)
- DECIM, 4, decimation factor, 1..256
- DEPTH, 8, FIFO entries, power of 2, 2..256
- AW, 3, log2(DEPTH)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  filter output valid; no ready returned
- in_sample  in  WIDTH signed  filter averaged sample
- clear  in  1  synchronous flush of FIFO, phase and status
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid=1
- out_sample  out  WIDTH signed  FIFO head (show-ahead)
- fifo_level  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a kept sample was dropped
- drop_cnt  out  16  saturating count of dropped kept samples

## Operation
- Phase counter `ph` (8 bits) advances only on in_valid=1. Wrap DECIM-1 → 0. DECIM=1 keeps every sample.
- Sample is kept when in_valid=1 and ph==0. The first valid sample after reset or clear is therefore kept.
- Push = keep && (level<DEPTH || pop), where pop = out_valid && out_ready.
  - Pushing while full in the same cycle as a pop is legal. The level stays DEPTH.
- Drop = keep && level==DEPTH && !pop.
  - A drop sets overflow=1; it stays set until clear or reset.
  - A drop increments drop_cnt; it saturates at 16'hFFFF.
- Pop advances the read pointer. Pop on an empty FIFO is impossible, since out_valid=0.
- Pointers are AW bits and wrap modulo DEPTH. level is tracked in a separate AW+1-bit counter: +1 on push only, -1 on pop only, unchanged on both.
- Sample data passes through unmodified; no arithmetic, no width change.
- clear=1 has priority over everything else in that cycle:
  - level, pointers and ph go to 0; overflow and drop_cnt go to 0.
  - A concurrent in_valid sample is discarded and does not advance ph.
  - A concurrent pop is ignored.
- FIFO memory contents are not reset. out_sample is don't-care while out_valid=0, but must not be X after reset: drive 0 when empty.

## Timing
- Reset values: out_valid=0, out_sample=0, fifo_level=0, overflow=0, drop_cnt=0, ph=0.
- Latency: a sample kept at rising edge t is visible at out_valid/out_sample after edge t, i.e. in cycle t+1, when the FIFO was empty.
- out_valid and fifo_level are registered-state derived; no combinational path from in_valid or out_ready to out_valid.
- out_sample is a combinational read of mem[rd_ptr]; it changes only after an edge.
- Throughput: 1 push and 1 pop per cycle sustained.
- Handshake: out_sample must hold stable while out_valid=1 && out_ready=0.
- Asynchronous reset mid-stream aborts immediately: all outputs take reset values and buffered data is lost.

## Configuration
- Macro `MA_DECIM_DROP_CNT_EN`.
  - Defined: drop_cnt implemented as described.
  - Undefined: no counter register; drop_cnt tied to 16'h0000. overflow remains functional.

## Test plan
- Reset then stream in_valid=1 with samples 0,1,2,…,11, DECIM=4, out_ready=1:
  - kept 0, 4, 8 appear on the output, one cycle after each push;
  - fifo_level never exceeds 1; overflow=0.
- DECIM=1, DEPTH=8, out_ready=0, 10 consecutive samples 100..109:
  - fifo_level=8, heads 100..107 buffered;
  - 108 and 109 dropped; overflow=1, drop_cnt=2 (0 with macro undefined).
- Full FIFO, out_ready=1 and kept sample 500 in the same cycle:
  - the pop occurs; 500 is accepted; fifo_level stays 8; no drop.
- Gapped in_valid (1,0,0,1,…), DECIM=2, samples 10,20,30,40:
  - kept 10 and 30; ph advances only on valid cycles.
- clear asserted with fifo_level=5, overflow=1, and in_valid=1 carrying sample 77:
  - next cycle fifo_level=0, out_valid=0, overflow=0, drop_cnt=0;
  - 77 is not stored; the next valid sample is kept.
- Assert rst_n=0 asynchronously mid-burst with fifo_level=3:
  - outputs go to reset values immediately;
  - after release, the first sample is kept.
